// File: rtl/hlsm_mul_arbiter.sv
// hlsm_mul_arbiter
// Round-robin arbiter in front of one shared pipelined signed multiplier.
// Each requester may have at most one product in flight. Results come back
// in grant order, tagged with the requester id, MUL_LAT edges after the grant.

module hlsm_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 16,
    parameter int MUL_LAT = 2
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NREQ-1:0]           Req,
    input  logic [NREQ*WIDTH-1:0]     OpA,
    input  logic [NREQ*WIDTH-1:0]     OpB,
    output logic [NREQ-1:0]           Gnt,
    output logic                      RspValid,
    output logic [$clog2(NREQ)-1:0]   RspId,
    output logic [2*WIDTH-1:0]        RspData,
    output logic                      Busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int DW  = 2 * WIDTH;

    // Arbitration state
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] set_mask;
    logic [NREQ-1:0] clr_mask;
    logic [NREQ-1:0] gnt_q;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gnt_id;
    logic            found;
    int              rr_idx;

    // Operand stage, captured at the grant edge
    logic signed [WIDTH-1:0] a_op;
    logic signed [WIDTH-1:0] b_op;
    logic [IDW-1:0]          id_op;
    logic                    v_op;
    logic signed [DW-1:0]    prod;

    // Product pipeline: stage i is loaded from chain slot i; the top stage
    // is the response register and holds its data between responses.
    logic [MUL_LAT-1:0]           v_sr;
    logic [MUL_LAT*IDW-1:0]       id_sr;
    logic [MUL_LAT*DW-1:0]        p_sr;
    logic [MUL_LAT:0]             v_chain;
    logic [(MUL_LAT+1)*IDW-1:0]   id_chain;
    logic [(MUL_LAT+1)*DW-1:0]    p_chain;

    assign eligible = Req & ~pending;
    assign prod     = DW'(a_op) * DW'(b_op);
    assign v_chain  = {v_sr, v_op};
    assign id_chain = {id_sr, id_op};
    assign p_chain  = {p_sr, prod};

    // Find the first eligible requester at or after the round-robin pointer
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        found  = 1'b0;
        gnt_id = '0;
        rr_idx = 0;
        for (int off = 0; off < NREQ; off++) begin
            rr_idx = int'(ptr) + off;
            if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
            if (!found && eligible[IDW'(rr_idx)]) begin
                found  = 1'b1;
                gnt_id = IDW'(rr_idx);
            end
        end
    end

    // Pending bits set on grant and cleared as the response register loads
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (found) set_mask[gnt_id] = 1'b1;
        if (v_chain[MUL_LAT-1]) clr_mask[id_chain[(MUL_LAT-1)*IDW +: IDW]] = 1'b1;
    end

    // Grant, pointer, pending flags and operand capture
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            gnt_q   <= '0;
            pending <= '0;
            ptr     <= '0;
            a_op    <= '0;
            b_op    <= '0;
            id_op   <= '0;
            v_op    <= 1'b0;
        end else begin
            gnt_q   <= set_mask;
            pending <= (pending & ~clr_mask) | set_mask;
            v_op    <= found;
            if (found) begin
                a_op  <= OpA[int'(gnt_id)*WIDTH +: WIDTH];
                b_op  <= OpB[int'(gnt_id)*WIDTH +: WIDTH];
                id_op <= gnt_id;
                ptr   <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
            end
        end
    end

    // Multiplier pipeline; the last stage only updates on a valid product
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            // NOTE: the data stages are reset too, because the top stage drives RspId/RspData, which must read 0 after reset.
            v_sr  <= '0;
            id_sr <= '0;
            p_sr  <= '0;
        end else begin
            v_sr <= v_chain[MUL_LAT-1:0];
            for (int i = 0; i < MUL_LAT; i++) begin
                if (i != MUL_LAT-1 || v_chain[i]) begin
                    id_sr[i*IDW +: IDW] <= id_chain[i*IDW +: IDW];
                    p_sr[i*DW +: DW]    <= p_chain[i*DW +: DW];
                end
            end
        end
    end

    assign Gnt      = gnt_q;
    assign RspValid = v_chain[MUL_LAT];
    assign RspId    = id_chain[MUL_LAT*IDW +: IDW];
    assign RspData  = p_chain[MUL_LAT*DW +: DW];
    assign Busy     = |pending;

endmodule
